// File: rtl/data_mem_responder.sv
// Word-wide data memory responder with a fixed access latency.
// One outstanding request; valid/ready on both request and response channels.
module data_mem_responder #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit DIRECT = (LATENCY == 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [MEM_DEPTH];

  logic          accept;
  logic          commit;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [29:0]   c_idx;
  logic          c_err;
  logic [AW-1:0] c_row;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  assign c_idx = c_addr[31:2];
  assign c_err = (c_addr[1:0] != 2'b00) ||
                 ({2'b00, c_idx} >= 32'(MEM_DEPTH));
  assign c_row = c_idx[AW-1:0];

  // Pick the access to commit: live inputs on a direct accept, else held copy.
  always_comb begin
    commit  = 1'b0;
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    unique case (1'b1)
      (state == IDLE): begin
        if (DIRECT && accept) begin
          commit  = 1'b1;
          c_we    = req_we;
          c_addr  = req_addr;
          c_wdata = req_wdata;
        end
      end
      (state == WAIT): commit = (cnt == 4'd0);
      default: ;
    endcase
  end

  // Storage write; never touched by reset, and blocked while reset is held.
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err && !reset) begin
      mem[c_row] <= c_wdata;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            busy    <= 1'b1;
            if (!DIRECT) begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        state      <= RESP;
        busy       <= 1'b1;
        resp_valid <= 1'b1;
        resp_err   <= c_err;
        resp_rdata <= (c_we || c_err) ? 32'h0 : mem[c_row];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: latency-2 instance for the main scenarios,
// latency-1 instance for back-to-back streaming.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT0  = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_req_we = 1'b0;
  logic [31:0] b_req_addr = 32'h0;
  logic [31:0] b_req_wdata = 32'h0;
  logic        b_resp_valid;
  logic        b_resp_ready = 1'b0;
  logic [31:0] b_resp_rdata;
  logic        b_resp_err;
  logic        b_busy;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] m0 [int];
  logic [31:0] m1 [int];

  always #5 clk = ~clk;

  data_mem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT0)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  data_mem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  function automatic exp_t predict(input bit sel, input logic we,
                                   input logic [31:0] addr,
                                   input logic [31:0] wdata);
    exp_t e;
    int idx;
    idx = int'(addr >> 2);
    e.err = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    e.rdata = 32'h0;
    if (!e.err) begin
      if (we) begin
        if (sel) m1[idx] = wdata;
        else m0[idx] = wdata;
      end else if (sel) begin
        e.rdata = m1.exists(idx) ? m1[idx] : 32'hx;
      end else begin
        e.rdata = m0.exists(idx) ? m0[idx] : 32'hx;
      end
    end
    return e;
  endfunction

  // One request on the latency-2 instance; resp_ready held low for stall cycles.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall);
    exp_t e;
    int n;
    logic [31:0] h_rdata;
    logic h_err;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_idle got=%b exp=1", req_ready);
    end
    resp_ready = (stall == 0);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    q0.push_back(predict(1'b0, we, addr, wdata));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = ~we;
    req_addr = $urandom;
    req_wdata = $urandom;
    n = 0;
    while (!resp_valid && n < 20) begin
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL busy_wait busy=%b req_ready=%b exp 1/0",
                 busy, req_ready);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== LAT0 - 1) begin
      failures++;
      $display("FAIL latency edges_after_accept=%0d exp=%0d",
               n + 1, LAT0);
    end
    h_rdata = resp_rdata;
    h_err = resp_err;
    repeat (stall) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== h_rdata ||
          resp_err !== h_err || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL resp_hold valid=%b rdata=%h err=%b ready=%b exp 1/%h/%b/0",
                 resp_valid, resp_rdata, resp_err, req_ready, h_rdata, h_err);
      end
    end
    resp_ready = 1'b1;
    e = q0.pop_front();
    checks++;
    if (resp_rdata !== e.rdata || resp_err !== e.err) begin
      failures++;
      $display("FAIL resp addr=%h rdata=%h err=%b exp %h/%b",
               addr, resp_rdata, resp_err, e.rdata, e.err);
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_handshake valid=%b req_ready=%b busy=%b exp 0/1/0",
               resp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp valid=%b rdata=%h err=%b exp 0/0/0",
               resp_valid, resp_rdata, resp_err);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b req_ready=%b exp 0/1",
               busy, req_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut1 ready=%b valid=%b busy=%b exp 1/0/0",
               b_req_ready, b_resp_valid, b_busy);
    end
  endtask

  task automatic test_write_read();
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_stall();
    do_req(1'b1, 32'h24, 32'hA5A55A5A, 0);
    do_req(1'b0, 32'h24, 32'h0, 5);
  endtask

  task automatic test_errors();
    do_req(1'b1, 32'h13, 32'hBAD0BAD0, 0);
    do_req(1'b0, 32'h10, 32'h0, 0);
    do_req(1'b0, 32'(4 * DEPTH), 32'h0, 2);
    do_req(1'b1, 32'(4 * DEPTH - 4), 32'h0BADF00D, 0);
    do_req(1'b0, 32'(4 * DEPTH - 4), 32'h0, 0);
  endtask

  task automatic test_reset_in_wait();
    do_req(1'b1, 32'h20, 32'hCAFE0001, 0);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_wait ready=%b busy=%b valid=%b exp 1/0/0",
               req_ready, busy, resp_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL no_resp_after_reset valid=%b ready=%b exp 0/1",
                 resp_valid, req_ready);
      end
    end
    do_req(1'b0, 32'h20, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [8];
    logic        wes [8];
    logic [31:0] wd [8];
    exp_t e;
    int k;
    int cyc;
    int got;
    int last_acc;
    logic acc;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 32'((i % 4) * 4);
      wes[i] = (i < 4);
      wd[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
    end
    k = 0;
    cyc = 0;
    got = 0;
    last_acc = -1;
    b_resp_ready = 1'b1;
    while (got < 8 && cyc < 60) begin
      b_req_valid = (k < 8);
      if (k < 8) begin
        b_req_we = wes[k];
        b_req_addr = addrs[k];
        b_req_wdata = wd[k];
      end
      acc = b_req_valid && b_req_ready;
      if (b_resp_valid) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL b2b_spurious_resp rdata=%h", b_resp_rdata);
        end else begin
          e = q1.pop_front();
          if (b_resp_rdata !== e.rdata || b_resp_err !== e.err) begin
            failures++;
            $display("FAIL b2b_resp idx=%0d rdata=%h err=%b exp %h/%b",
                     got, b_resp_rdata, b_resp_err, e.rdata, e.err);
          end
        end
        got++;
      end
      if (acc) begin
        q1.push_back(predict(1'b1, b_req_we, b_req_addr, b_req_wdata));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 2) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=2", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        checks++;
        if (b_resp_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_latency resp_valid=%b exp=1", b_resp_valid);
        end
      end
    end
    b_req_valid = 1'b0;
    checks++;
    if (got !== 8) begin
      failures++;
      $display("FAIL b2b_timeout responses=%0d exp=8", got);
    end
    @(posedge clk); #1;
    b_resp_ready = 1'b0;
    checks++;
    if (b_busy !== 1'b0 || b_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle busy=%b ready=%b exp 0/1", b_busy, b_req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall();
    test_errors();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
